router_sync: RTL

- Channel controller between the router FSM, the three output FIFOs and the three read ports.
- Latches the destination address from the packet header and steers the FSM's write enable to the addressed FIFO.
- Returns the addressed FIFO's full flag to the FSM and drives per-port valid_out.
- Runs a per-port read timeout that issues a one-cycle soft reset to a FIFO whose data is not read in time.

---
 rtl/router_sync.sv | 94 +++++++++
 1 files changed

// File: rtl/router_sync.sv
// rtl/router_sync.sv - router channel controller: address latch, write steering, per-port read timeout
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CW      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       detect_addr,
    input  logic       pkt_vld,
    input  logic [1:0] data_in,
    input  logic       write_en_reg,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [1:0]    addr_q, addr_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    logic [2:0]    soft_q, soft_d;
    logic [2:0]    vld, rd, full;

    assign vld  = {~empty_2, ~empty_1, ~empty_0};
    assign rd   = {read_enb_2, read_enb_1, read_enb_0};
    assign full = {full_2, full_1, full_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    assign soft_reset_0 = soft_q[0];
    assign soft_reset_1 = soft_q[1];
    assign soft_reset_2 = soft_q[2];

    always_comb begin
        addr_d = addr_q;
        if (detect_addr && pkt_vld)
            addr_d = data_in;
    end

    // Address 3 is the idle/invalid code: it gates off both steering outputs.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        if (addr_q != 2'b11) begin
            write_enb[addr_q] = write_en_reg;
            fifo_full         = full[addr_q];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]  = '0;
            soft_d[i] = 1'b0;
            if (vld[i] && !rd[i]) begin
                if (cnt_q[i] == LAST)
                    soft_d[i] = 1'b1;
                else
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 2'b11;
            soft_q <= 3'b000;
            for (int i = 0; i < 3; i++)
                cnt_q[i] <= '0;
        end else begin
            addr_q <= addr_d;
            soft_q <= soft_d;
            for (int i = 0; i < 3; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
